// File: rtl/sound_pkg.sv
// Shared types and constants for the game sound sequencer.
package sound_pkg;

    localparam logic [1:0] SND_NONE    = 2'd0;
    localparam logic [1:0] SND_CLICK   = 2'd1;
    localparam logic [1:0] SND_ERROR   = 2'd2;
    localparam logic [1:0] SND_VICTORY = 2'd3;

    // Half-periods in clk cycles at 50 MHz
    localparam logic [15:0] HALF_CLICK = 16'd2000;   // 12.5 kHz
    localparam logic [15:0] HALF_ERROR = 16'd50000;  // 500 Hz
    localparam logic [15:0] HALF_C5    = 16'd47801;
    localparam logic [15:0] HALF_E5    = 16'd37922;
    localparam logic [15:0] HALF_G5    = 16'd31888;
    localparam logic [15:0] HALF_C6    = 16'd23889;

    localparam int unsigned MAX_SEGS = 4;

    typedef struct packed {
        logic        is_tone;
        logic [15:0] half;
        logic [5:0]  dur;
        logic        last;
    } segment_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    function automatic segment_t mk_seg(input logic is_tone, input logic [15:0] half,
                                        input logic [5:0] dur, input logic last);
        segment_t s;
        s.is_tone = is_tone;
        s.half    = half;
        s.dur     = dur;
        s.last    = last;
        return s;
    endfunction

endpackage

// File: rtl/sound_pattern_rom.sv
// Combinational pattern table: (sequence id, segment index) -> segment.
module sound_pattern_rom
    import sound_pkg::*;
(
    input  logic [1:0]                    id_i,
    input  logic [$clog2(MAX_SEGS)-1:0]   seg_idx_i,
    output segment_t                      seg_o
);

    // Table lookup; unused slots fall back to a one-tick terminating rest
    always_comb begin
        seg_o = mk_seg(1'b0, '0, 6'd1, 1'b1);
        case (id_i)
            SND_CLICK: begin
                if (seg_idx_i == 2'd0) seg_o = mk_seg(1'b1, HALF_CLICK, 6'd5, 1'b1);
            end
            SND_ERROR: begin
                case (seg_idx_i)
                    2'd0:    seg_o = mk_seg(1'b1, HALF_ERROR, 6'd20, 1'b0);
                    2'd1:    seg_o = mk_seg(1'b0, '0,         6'd10, 1'b0);
                    2'd2:    seg_o = mk_seg(1'b1, HALF_ERROR, 6'd20, 1'b1);
                    default: ;
                endcase
            end
            SND_VICTORY: begin
                case (seg_idx_i)
                    2'd0:    seg_o = mk_seg(1'b1, HALF_C5, 6'd15, 1'b0);
                    2'd1:    seg_o = mk_seg(1'b1, HALF_E5, 6'd15, 1'b0);
                    2'd2:    seg_o = mk_seg(1'b1, HALF_G5, 6'd15, 1'b0);
                    default: seg_o = mk_seg(1'b1, HALF_C6, 6'd15, 1'b1);
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sound_sequencer.sv
// Game sound sequencer: priority arbitration of click/error/victory requests,
// segment sequencing from sound_pattern_rom, and square-wave generation.
// Optional macro SOUND_MUTE_EN adds a mute input that holds sndpin high.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 500000,
    parameter int unsigned TONE_SHIFT  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_click,
    input  logic       req_error,
    input  logic       req_victory,
`ifdef SOUND_MUTE_EN
    input  logic       mute,
`endif
    output logic       sndpin,
    output logic       busy,
    output logic [1:0] playing_id,
    output logic       done
);

    localparam int unsigned  TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    id_q, id_d;
    logic [1:0]    seg_idx_q, seg_idx_d;
    segment_t      seg_q, seg_d, rom_seg;
    logic [TW-1:0] tick_q, tick_d;
    logic [5:0]    dur_q, dur_d;
    logic [15:0]   half_cnt_q, half_cnt_d;
    logic          snd_q, snd_d;
    logic          done_q, done_d;

    logic [1:0]    req_id;
    logic [15:0]   half_sh, half_eff;
    logic          seg_end, accept;

    sound_pattern_rom u_rom (
        .id_i      (id_q),
        .seg_idx_i (seg_idx_q),
        .seg_o     (rom_seg)
    );

    // Fixed-priority request encode, effective half-period, and accept decision
    always_comb begin
        if (req_victory)    req_id = SND_VICTORY;
        else if (req_error) req_id = SND_ERROR;
        else if (req_click) req_id = SND_CLICK;
        else                req_id = SND_NONE;

        half_sh  = seg_q.half >> TONE_SHIFT;
        half_eff = (half_sh == '0) ? 16'd1 : half_sh;

        seg_end = (state_q == ST_PLAY) && (tick_q == TICK_LAST)
                  && (dur_q == seg_q.dur - 6'd1);
        // A final segment ending this cycle frees the sequencer like IDLE does
        accept  = (req_id != SND_NONE)
                  && ((state_q == ST_IDLE) || (req_id > id_q) || (seg_end && seg_q.last));
    end

    // Next-state logic for the IDLE/LOAD/PLAY sequencer and its counters
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        seg_idx_d  = seg_idx_q;
        seg_d      = seg_q;
        tick_d     = tick_q;
        dur_d      = dur_q;
        half_cnt_d = half_cnt_q;
        snd_d      = snd_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
                seg_d      = rom_seg;
                tick_d     = '0;
                dur_d      = '0;
                half_cnt_d = '0;
                snd_d      = ~rom_seg.is_tone;
                state_d    = ST_PLAY;
            end
            ST_PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    dur_d  = dur_q + 6'd1;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
                if (seg_q.is_tone) begin
                    if (half_cnt_q == half_eff - 16'd1) begin
                        half_cnt_d = '0;
                        snd_d      = ~snd_q;
                    end else begin
                        half_cnt_d = half_cnt_q + 16'd1;
                    end
                end
                if (seg_end) begin
                    tick_d     = '0;
                    dur_d      = '0;
                    half_cnt_d = '0;
                    snd_d      = 1'b1;
                    if (seg_q.last) begin
                        state_d   = ST_IDLE;
                        id_d      = SND_NONE;
                        seg_idx_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        seg_idx_d = seg_idx_q + 2'd1;
                        state_d   = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d    = ST_LOAD;
            id_d       = req_id;
            seg_idx_d  = '0;
            tick_d     = '0;
            dur_d      = '0;
            half_cnt_d = '0;
            snd_d      = 1'b1;
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            id_q       <= SND_NONE;
            seg_idx_q  <= '0;
            seg_q      <= '0;
            tick_q     <= '0;
            dur_q      <= '0;
            half_cnt_q <= '0;
            snd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            seg_idx_q  <= seg_idx_d;
            seg_q      <= seg_d;
            tick_q     <= tick_d;
            dur_q      <= dur_d;
            half_cnt_q <= half_cnt_d;
            snd_q      <= snd_d;
            done_q     <= done_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign playing_id = id_q;
    assign done       = done_q;
`ifdef SOUND_MUTE_EN
    assign sndpin     = snd_q | mute;
`else
    assign sndpin     = snd_q;
`endif

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: arbitration vector table,
// full-sequence waveform checks, and a done-pulse scoreboard.
module tb_sound_sequencer;

    localparam int TICK  = 400;
    localparam int SHIFT = 6;

    logic       clk;
    logic       rst;
    logic       req_click, req_error, req_victory;
    logic       sndpin, busy, done;
    logic [1:0] playing_id;
`ifdef SOUND_MUTE_EN
    logic       mute;
    initial mute = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_done_q[$];

    sound_sequencer #(.TICK_CYCLES(TICK), .TONE_SHIFT(SHIFT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_click   (req_click),
        .req_error   (req_error),
        .req_victory (req_victory),
`ifdef SOUND_MUTE_EN
        .mute        (mute),
`endif
        .sndpin      (sndpin),
        .busy        (busy),
        .playing_id  (playing_id),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the next expected cycle
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("done_cycle", cyc, exp_done_q.pop_front());
            end
        end
    end

    task automatic pulse(input logic [2:0] r, output int n);
        n = cyc;
        {req_victory, req_error, req_click} = r;
        @(negedge clk);
        {req_victory, req_error, req_click} = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_outputs(input string nm, input logic s, input logic b,
                               input logic [1:0] id);
        check({nm, "_sndpin"}, sndpin, s);
        check({nm, "_busy"}, busy, b);
        check({nm, "_id"}, playing_id, id);
    endtask

    // half == 0 means a rest segment; otherwise tone starting low
    task automatic chk_seg(input string nm, input int half, input int len);
        for (int k = 0; k < len; k++) begin
            check(nm, sndpin, (half == 0) ? 1 : ((k / half) % 2));
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0] start;   // {victory,error,click} first request, 0 = none
        logic [2:0] req;     // follow-up request
        logic [1:0] exp_id;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n, m;
        vecs[0] = '{3'b000, 3'b001, 2'd1};
        vecs[1] = '{3'b000, 3'b011, 2'd2};
        vecs[2] = '{3'b000, 3'b101, 2'd3};
        vecs[3] = '{3'b000, 3'b111, 2'd3};
        vecs[4] = '{3'b010, 3'b001, 2'd2};
        vecs[5] = '{3'b010, 3'b010, 2'd2};
        vecs[6] = '{3'b010, 3'b100, 2'd3};
        vecs[7] = '{3'b001, 3'b010, 2'd2};
        vecs[8] = '{3'b100, 3'b010, 2'd3};

        rst = 1'b1;
        {req_victory, req_error, req_click} = 3'b000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_outputs("reset", 1'b1, 1'b0, 2'd0);
            check("reset_done", done, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Arbitration table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            if (vecs[i].start != 3'b000) begin
                pulse(vecs[i].start, n);
                repeat (5) @(negedge clk);
            end
            pulse(vecs[i].req, n);
            check($sformatf("arb%0d_id", i), playing_id, vecs[i].exp_id);
            check($sformatf("arb%0d_busy", i), busy, 1);
        end

        // Full click
        do_reset();
        pulse(3'b001, n);
        exp_done_q.push_back(n + 5 * TICK + 2);
        chk_outputs("click_load", 1'b1, 1'b1, 2'd1);
        @(negedge clk);
        chk_seg("click_tone", 2000 >> SHIFT, 5 * TICK);
        chk_outputs("click_end", 1'b1, 1'b0, 2'd0);
        repeat (5) @(negedge clk);
        chk_outputs("click_idle", 1'b1, 1'b0, 2'd0);

        // Full error: tone, rest, tone with single-cycle LOAD gaps
        pulse(3'b010, n);
        exp_done_q.push_back(n + 50 * TICK + 4);
        chk_outputs("err_load0", 1'b1, 1'b1, 2'd2);
        @(negedge clk);
        chk_seg("err_tone0", 50000 >> SHIFT, 20 * TICK);
        chk_outputs("err_load1", 1'b1, 1'b1, 2'd2);
        @(negedge clk);
        chk_seg("err_rest", 0, 10 * TICK);
        chk_outputs("err_load2", 1'b1, 1'b1, 2'd2);
        @(negedge clk);
        chk_seg("err_tone2", 50000 >> SHIFT, 20 * TICK);
        chk_outputs("err_end", 1'b1, 1'b0, 2'd0);

        // Same-cycle click+victory plays the whole victory jingle
        pulse(3'b101, n);
        exp_done_q.push_back(n + 60 * TICK + 5);
        chk_outputs("vic_load0", 1'b1, 1'b1, 2'd3);
        @(negedge clk);
        chk_seg("vic_c5", 47801 >> SHIFT, 15 * TICK);
        chk_outputs("vic_load1", 1'b1, 1'b1, 2'd3);
        @(negedge clk);
        chk_seg("vic_e5", 37922 >> SHIFT, 15 * TICK);
        chk_outputs("vic_load2", 1'b1, 1'b1, 2'd3);
        @(negedge clk);
        chk_seg("vic_g5", 31888 >> SHIFT, 15 * TICK);
        chk_outputs("vic_load3", 1'b1, 1'b1, 2'd3);
        @(negedge clk);
        chk_seg("vic_c6", 23889 >> SHIFT, 15 * TICK);
        chk_outputs("vic_end", 1'b1, 1'b0, 2'd0);

        // Preemption of ERROR by VICTORY, then reset mid-VICTORY
        pulse(3'b010, n);
        repeat (20) @(negedge clk);
        pulse(3'b001, n);
        check("pre_click_drop", playing_id, 2);
        repeat (5) @(negedge clk);
        pulse(3'b100, n);
        chk_outputs("pre_vic_load", 1'b1, 1'b1, 2'd3);
        @(negedge clk);
        chk_seg("pre_vic_c5", 47801 >> SHIFT, 1000);
        rst = 1'b1;
        @(negedge clk);
        chk_outputs("mid_reset", 1'b1, 1'b0, 2'd0);
        check("mid_reset_done", done, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Final segment end coinciding with a new equal-priority request
        pulse(3'b001, n);
        exp_done_q.push_back(n + 5 * TICK + 2);
        repeat (5 * TICK) @(negedge clk);
        pulse(3'b001, m);
        exp_done_q.push_back(m + 5 * TICK + 2);
        check("coinc_done", done, 1);
        chk_outputs("coinc_load", 1'b1, 1'b1, 2'd1);
        repeat (5 * TICK + 1) @(negedge clk);
        chk_outputs("coinc_end", 1'b1, 1'b0, 2'd0);
        repeat (3) @(negedge clk);

        check("done_pending", exp_done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
